fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 102 ++++++++++
 tb/tb_fetch_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences fetch addresses into a one-cycle synchronous
// instruction memory and lends the memory port to a loader while idle or halted.
module fetch_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  stall,
    input  logic                  branch_en,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_en,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic [1:0]            state_o,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  fetch_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] issue_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (halt_req)   state_nxt = S_HALT;
                else if (stall) state_nxt = S_STALL;
            end
            S_STALL: begin
                if (halt_req)    state_nxt = S_HALT;
                else if (!stall) state_nxt = S_RUN;
            end
            S_HALT: begin
                if (start) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake: mem_en qualifies mem_addr in the same cycle; instr_valid qualifies
    // fetch_pc one cycle later; stall is the downstream not-ready and blocks any issue.
    always_comb begin
        issue      = (state == S_RUN) && !halt_req && !stall;
        ld_gnt     = ((state == S_IDLE) || (state == S_HALT)) && ld_req && !start;
        issue_addr = branch_en ? branch_target : pc;
        mem_en     = issue || ld_gnt;
        halted     = (state == S_HALT);
        if (ld_gnt)     mem_addr = ld_addr;
        else if (issue) mem_addr = issue_addr;
        else            mem_addr = pc;
    end

    assign state_o = state;

    // Loader accesses never set instr_valid; only fetch issues return instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instr_valid <= 1'b0;
            fetch_pc    <= '0;
            fetch_count <= '0;
        end else begin
            instr_valid <= issue;
            if (issue) begin
                pc       <= issue_addr + 1'b1;
                fetch_pc <= issue_addr;
            end
            if ((state == S_IDLE) && start) begin
                fetch_count <= '0;
            end else if (issue && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: cycle driver plus reference model, with issued addresses
// queued and matched against instr_valid/fetch_pc by an independent monitor.
module tb_fetch_ctrl;

    localparam int AW = 9;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, halt_req, stall, branch_en, ld_req;
    logic [AW-1:0] branch_target, ld_addr;
    logic          ld_gnt, mem_en, instr_valid, halted;
    logic [AW-1:0] mem_addr, fetch_pc;
    logic [1:0]    state_o;
    logic [CW-1:0] fetch_count;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .stall(stall),
        .branch_en(branch_en), .branch_target(branch_target), .ld_req(ld_req),
        .ld_addr(ld_addr), .ld_gnt(ld_gnt), .mem_addr(mem_addr), .mem_en(mem_en),
        .instr_valid(instr_valid), .fetch_pc(fetch_pc), .state_o(state_o),
        .halted(halted), .fetch_count(fetch_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW-1:0] exp_q[$];

    // Reference model: mode 0 idle, 1 running, 2 stalled, 3 halted (the published state_o codes)
    int m_mode;
    int m_pc;
    int m_cnt;
    int m_fpc;
    bit m_vld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_cnt = 0; m_fpc = 0; m_vld = 0;
        exp_q.delete();
    endtask

    task automatic cycle(input bit s, input bit hr, input bit sl, input bit be,
                         input int bt, input bit lr, input int la);
        bit iss, gnt;
        int a;
        @(negedge clk);
        start = s; halt_req = hr; stall = sl; branch_en = be;
        branch_target = AW'(bt); ld_req = lr; ld_addr = AW'(la);
        #1;
        iss = (m_mode == 1) && !hr && !sl;
        gnt = (m_mode == 0 || m_mode == 3) && lr && !s;
        if (gnt)            a = la;
        else if (iss && be) a = bt;
        else                a = m_pc;
        check("mem_en", 32'(mem_en), 32'(iss || gnt));
        check("mem_addr", 32'(mem_addr), 32'(a));
        check("ld_gnt", 32'(ld_gnt), 32'(gnt));
        check("state_o", 32'(state_o), 32'(m_mode));
        check("halted", 32'(halted), 32'(m_mode == 3));
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
        check("instr_valid", 32'(instr_valid), 32'(m_vld));
        check("fetch_pc", 32'(fetch_pc), 32'(m_fpc));
        m_vld = iss;
        if (iss) begin
            exp_q.push_back(AW'(a));
            m_pc  = (a + 1) % (1 << AW);
            m_fpc = a;
            if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
        end
        case (m_mode)
            0: if (s) begin m_mode = 1; m_cnt = 0; end
            1: if (hr) m_mode = 3; else if (sl) m_mode = 2;
            2: if (hr) m_mode = 3; else if (!sl) m_mode = 1;
            default: if (s) m_mode = 1;
        endcase
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every returned instruction must match the oldest outstanding issue.
    always @(posedge clk) begin
        #2;
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_instr_valid", 32'(fetch_pc), 32'hFFFF_FFFF);
            end else begin
                check("sb_fetch_pc", 32'(fetch_pc), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 0; halt_req = 0; stall = 0; branch_en = 0; ld_req = 0;
        branch_target = '0; ld_addr = '0;
        model_reset();
        #3;
        check("rst_state", 32'(state_o), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_fetch_pc", 32'(fetch_pc), 0);
        check("rst_count", 32'(fetch_count), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential start-up, then the branch, self-branch, wrap and stall corners
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(4);
        check("count_after_4", 32'(m_cnt), 4);
        idle(1);
        cycle(0, 0, 0, 1, 'h40, 0, 0);
        idle(1);
        cycle(0, 0, 0, 1, m_pc, 0, 0);
        idle(1);
        cycle(0, 0, 0, 1, 'h1FF, 0, 0);
        idle(2);
        cycle(0, 0, 0, 1, 6, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 'h99, 0, 0);
        cycle(0, 0, 0, 1, 'h99, 0, 0);
        idle(2);

        // Halt, loader access, then start while the loader still requests
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1, 'h10);
        cycle(1, 1, 0, 0, 0, 1, 'h10);
        idle(40);

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, (1 << AW) - 1), $urandom_range(0, 2) == 0,
                  $urandom_range(0, (1 << AW) - 1));
        end

        // Asynchronous reset between edges with an instruction in flight
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(instr_valid), 0);
        check("async_rst_state", 32'(state_o), 0);
        check("async_rst_count", 32'(fetch_count), 0);
        check("async_rst_fetch_pc", 32'(fetch_pc), 0);
        check("async_rst_mem_addr", 32'(mem_addr), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        cycle(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
